// File: rtl/vram_pkg.sv
// vram_pkg: shared definitions for the video RAM arbiter.
//   - VRAM_ADDR_W / VRAM_DATA_W / VRAM_MASK_W: geometry of the 16K x 24 single-port RAM,
//     written in 4-bit nibbles (one write-enable bit per nibble).
//   - req_id_e: identifies which requester owns an access or a pending read return.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 14;
    localparam int unsigned VRAM_DATA_W = 24;
    localparam int unsigned VRAM_MASK_W = VRAM_DATA_W / 4;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_BLT  = 2'd2,
        REQ_CPU  = 2'd3
    } req_id_e;

endpackage

// File: rtl/arb_rr2_lock.sv
// arb_rr2_lock: two-way round-robin arbiter with a lock for requester A and a
// starvation guard for requester B.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req_a    in   requester A (blitter) wants an access
//   req_b    in   requester B (CPU) wants an access
//   lock_a   in   A asks to keep the grant on consecutive cycles
//   block    in   a higher-priority requester owns this cycle; nobody here is granted
//   gnt_a    out  A granted this cycle
//   gnt_b    out  B granted this cycle
//
// Round-robin state remembers which of A/B was granted last (reset: B, so A wins first).
// While A holds a lock, B's waiting cycles are counted; when the count reaches
// MAX_WAIT-1, B is granted on that cycle regardless of the lock.
module arb_rr2_lock #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_a,
    input  logic block,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT - 1);

    logic             last_a_q, last_a_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             lock_hold;
    logic             starved;

    // Lock only applies when A actually owned the previous A/B grant.
    assign lock_hold = lock_a && req_a && last_a_q;
    assign starved   = (wait_cnt_q == CNT_LIMIT);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!block) begin
            if (req_a && req_b) begin
                if (lock_hold) begin
                    if (starved) begin
                        gnt_b = 1'b1;
                    end else begin
                        gnt_a = 1'b1;
                    end
                end else if (last_a_q) begin
                    gnt_b = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_comb begin
        last_a_d = last_a_q;
        if (gnt_a) begin
            last_a_d = 1'b1;
        end else if (gnt_b) begin
            last_a_d = 1'b0;
        end
    end

    // Only cycles that A wins under lock count; cycles lost to a blocking
    // requester leave the count unchanged.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_b || gnt_b) begin
            wait_cnt_d = '0;
        end else if (gnt_a && lock_a && (wait_cnt_q != CNT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_a_q   <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            last_a_q   <= last_a_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM (registered read, nibble write
// mask) between video scan-out, blitter and CPU. One access per clock.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   vid_req/vid_addr                 video read request (highest priority)
//   vid_ack, vid_rvalid              accepted this cycle / read data valid next cycle
//   blt_req/blt_lock/blt_addr/       blitter request, lock, address,
//   blt_we/blt_wdata                 nibble write mask (0 = read), write data
//   blt_ack, blt_rvalid              accepted / read data valid
//   cpu_req/cpu_addr/cpu_we/         CPU request, address, nibble mask (0 = read),
//   cpu_wdata                        write data
//   cpu_ack, cpu_rvalid              accepted / read data valid
//   rdata                            shared read data (RAM output), qualified by *_rvalid
//   ram_addr/ram_we/ram_wdata        RAM port drive
//   ram_rdata                        RAM registered read data
//
// Video always wins; blitter and CPU share the rest through arb_rr2_lock.
// A tag register remembers who issued the read in flight so the right
// *_rvalid fires one cycle after the ack.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W       = VRAM_ADDR_W,
    parameter int unsigned DATA_W       = VRAM_DATA_W,
    parameter int unsigned MASK_W       = VRAM_MASK_W,
    parameter int unsigned CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,

    input  logic              blt_req,
    input  logic              blt_lock,
    input  logic [ADDR_W-1:0] blt_addr,
    input  logic [MASK_W-1:0] blt_we,
    input  logic [DATA_W-1:0] blt_wdata,
    output logic              blt_ack,
    output logic              blt_rvalid,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [MASK_W-1:0] cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [MASK_W-1:0] ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              blt_gnt;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] addr_q;
    req_id_e           rv_tag_q, rv_tag_d;

    arb_rr2_lock #(
        .MAX_WAIT (CPU_MAX_WAIT)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (blt_req),
        .req_b   (cpu_req),
        .lock_a  (blt_lock),
        .block   (vid_req),
        .gnt_a   (blt_gnt),
        .gnt_b   (cpu_gnt)
    );

    // Acks are suppressed while reset is asserted so no access reaches the RAM.
    assign vid_ack = reset_n & vid_req;
    assign blt_ack = reset_n & blt_gnt;
    assign cpu_ack = reset_n & cpu_gnt;

    // Idle cycles keep the last address on the RAM and never write.
    always_comb begin
        ram_addr  = addr_q;
        ram_we    = '0;
        ram_wdata = '0;
        rv_tag_d  = REQ_NONE;
        if (vid_ack) begin
            ram_addr = vid_addr;
            rv_tag_d = REQ_VID;
        end else if (blt_ack) begin
            ram_addr  = blt_addr;
            ram_we    = blt_we;
            ram_wdata = blt_wdata;
            if (blt_we == '0) begin
                rv_tag_d = REQ_BLT;
            end
        end else if (cpu_ack) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
            if (cpu_we == '0) begin
                rv_tag_d = REQ_CPU;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            rv_tag_q <= REQ_NONE;
        end else begin
            addr_q   <= ram_addr;
            rv_tag_q <= rv_tag_d;
        end
    end

    assign vid_rvalid = (rv_tag_q == REQ_VID);
    assign blt_rvalid = (rv_tag_q == REQ_BLT);
    assign cpu_rvalid = (rv_tag_q == REQ_CPU);
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 24;
    localparam int MW   = 6;
    localparam int MAXW = 8;
    localparam int DEPTH = 16384;

    logic          clk;
    logic          reset_n;
    logic          vid_req, vid_ack, vid_rvalid;
    logic [AW-1:0] vid_addr;
    logic          blt_req, blt_lock, blt_ack, blt_rvalid;
    logic [AW-1:0] blt_addr;
    logic [MW-1:0] blt_we;
    logic [DW-1:0] blt_wdata;
    logic          cpu_req, cpu_ack, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [MW-1:0] cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    vram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MASK_W       (MW),
        .CPU_MAX_WAIT (MAXW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .blt_req    (blt_req),
        .blt_lock   (blt_lock),
        .blt_addr   (blt_addr),
        .blt_we     (blt_we),
        .blt_wdata  (blt_wdata),
        .blt_ack    (blt_ack),
        .blt_rvalid (blt_rvalid),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [31:0] v;
        v = i * 32'h0000A3C5 + 32'h0013579B;
        if (i == 5) return 24'h123456;
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < MW; k++) if (we[k]) r[4*k +: 4] = nw[4*k +: 4];
        return r;
    endfunction

    // Behavioural RAM attached to the DUT's RAM port (registered read).
    logic [DW-1:0] ram [0:DEPTH-1];
    bit preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            preloaded <= 1'b1;
        end else begin
            ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_we);
        end
        ram_rdata <= ram[ram_addr];
    end

    // Scoreboard entry: what the DUT must show during one cycle.
    typedef struct {
        logic [2:0]    ack;   // {cpu, blt, vid}
        logic [AW-1:0] addr;
        logic [MW-1:0] we;
        logic [DW-1:0] wdata;
        logic [2:0]    rv;    // {cpu, blt, vid}
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit done = 1'b0;
    bit final_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT against the next scoreboard entry every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset_n) begin
            check("rst_acks", {29'd0, cpu_ack, blt_ack, vid_ack}, 32'd0);
            check("rst_rvalid", {29'd0, cpu_rvalid, blt_rvalid, vid_rvalid}, 32'd0);
            check("rst_ram_we", {26'd0, ram_we}, 32'd0);
            check("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("acks", {29'd0, cpu_ack, blt_ack, vid_ack}, {29'd0, e.ack});
            check("ram_addr", {18'd0, ram_addr}, {18'd0, e.addr});
            check("ram_we", {26'd0, ram_we}, {26'd0, e.we});
            if (e.we != '0) check("ram_wdata", {8'd0, ram_wdata}, {8'd0, e.wdata});
            check("rvalid", {29'd0, cpu_rvalid, blt_rvalid, vid_rvalid}, {29'd0, e.rv});
            if (e.rv != '0) check("rdata", {8'd0, rdata}, {8'd0, e.rdata});
        end
        if (done && !final_done) begin
            check("queue_drained", exp_q.size(), 32'd0);
            final_done = 1'b1;
        end
    end

    // ---------------- reference model (spec rules, plain variables) ----------------
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            m_last_blt;   // last blitter/CPU winner was the blitter
    int            m_wait;       // CPU cycles lost to a locked blitter
    int            m_rv;         // 0 none, 1 vid, 2 blt, 3 cpu
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_last_addr;

    // Pending requests held by the stimulus side until acknowledged.
    bit            pv, pb, pc, lk;
    logic [AW-1:0] va, ba, ca;
    logic [MW-1:0] bwe, cwe;
    logic [DW-1:0] bwd, cwd;

    task automatic model_reset();
        m_last_blt  = 1'b0;
        m_wait      = 0;
        m_rv        = 0;
        m_rdata     = '0;
        m_last_addr = '0;
    endtask

    task automatic drive_inputs();
        vid_req = pv; vid_addr = va;
        blt_req = pb; blt_lock = lk; blt_addr = ba; blt_we = bwe; blt_wdata = bwd;
        cpu_req = pc; cpu_addr = ca; cpu_we = cwe; cpu_wdata = cwd;
    endtask

    task automatic rand_we(output logic [MW-1:0] we);
        if ($urandom_range(0, 1) == 0) we = '0;
        else we = MW'($urandom_range(1, 63));
    endtask

    task automatic arm(input int pv_pct, input int pb_pct, input int pc_pct,
                       input int base, input int span);
        if (!pv && int'($urandom_range(0, 99)) < pv_pct) begin
            pv = 1'b1; va = AW'(base + int'($urandom_range(0, span - 1)));
        end
        if (!pb && int'($urandom_range(0, 99)) < pb_pct) begin
            pb = 1'b1; ba = AW'(base + int'($urandom_range(0, span - 1)));
            rand_we(bwe); bwd = DW'($urandom);
        end
        if (!pc && int'($urandom_range(0, 99)) < pc_pct) begin
            pc = 1'b1; ca = AW'(base + int'($urandom_range(0, span - 1)));
            rand_we(cwe); cwd = DW'($urandom);
        end
    endtask

    // One clock of stimulus: drive requests, predict the cycle, advance.
    task automatic run_cycle();
        exp_t e;
        int g; // 0 none, 1 vid, 2 blt, 3 cpu
        drive_inputs();
        e.rv    = (m_rv == 1) ? 3'b001 : (m_rv == 2) ? 3'b010 : (m_rv == 3) ? 3'b100 : 3'b000;
        e.rdata = m_rdata;
        if (pv) g = 1;
        else if (pb && pc) begin
            if (lk && m_last_blt) g = (m_wait == MAXW - 1) ? 3 : 2;
            else g = m_last_blt ? 3 : 2;
        end
        else if (pb) g = 2;
        else if (pc) g = 3;
        else g = 0;

        if (!pc || g == 3) m_wait = 0;
        else if (g == 2 && lk && m_wait < MAXW - 1) m_wait++;
        if (g == 2) m_last_blt = 1'b1;
        if (g == 3) m_last_blt = 1'b0;

        e.ack = (g == 1) ? 3'b001 : (g == 2) ? 3'b010 : (g == 3) ? 3'b100 : 3'b000;
        e.we = '0; e.wdata = '0; e.addr = m_last_addr;
        case (g)
            1: e.addr = va;
            2: begin e.addr = ba; e.we = bwe; e.wdata = bwd; end
            3: begin e.addr = ca; e.we = cwe; e.wdata = cwd; end
            default: ;
        endcase
        m_rv = 0;
        if (g != 0) begin
            if (e.we == '0) begin
                m_rv = g; m_rdata = ref_mem[e.addr];
            end else begin
                ref_mem[e.addr] = merge(ref_mem[e.addr], e.wdata, e.we);
            end
        end
        m_last_addr = e.addr;
        exp_q.push_back(e);
        if (g == 1) pv = 1'b0;
        if (g == 2) pb = 1'b0;
        if (g == 3) pc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (pv || pb || pc); i++) run_cycle();
        run_cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        model_reset();
        lk = 1'b0;

        // Reset with every requester asking.
        reset_n = 1'b0;
        pv = 1'b1; va = 14'h0010;
        pb = 1'b1; ba = 14'h0020; bwe = '0; bwd = '0;
        pc = 1'b1; ca = 14'h0030; cwe = '0; cwd = '0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        drain();

        // Lone CPU read.
        pc = 1'b1; ca = 14'h0123; cwe = '0; cwd = '0;
        run_cycle();
        run_cycle();

        // Blitter and CPU continuous without lock, one video interjection.
        for (int i = 0; i < 10; i++) begin
            arm(0, 100, 100, 'h200, 16);
            if (i == 4) begin pv = 1'b1; va = 14'h0250; end
            run_cycle();
        end
        drain();

        // Locked blitter against a continuously waiting CPU.
        lk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            arm(0, 100, 100, 'h200, 16);
            run_cycle();
        end
        lk = 1'b0;
        drain();

        // Masked CPU write then read back of address 5.
        pc = 1'b1; ca = 14'd5; cwe = 6'b000011; cwd = 24'hABCDEF;
        run_cycle();
        pc = 1'b1; ca = 14'd5; cwe = '0; cwd = '0;
        run_cycle();
        run_cycle();
        run_cycle();

        // Reset right after a blitter read ack discards its return.
        pb = 1'b1; ba = 14'h0077; bwe = '0; bwd = '0;
        run_cycle();
        reset_n = 1'b0;
        pv = 1'b0; pb = 1'b0; pc = 1'b0;
        drive_inputs();
        void'(exp_q.pop_front());  // the in-flight return is dropped with the reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            arm(0, 100, 100, 'h280, 8);
            run_cycle();
        end
        drain();

        // Random traffic with collisions on a small address window.
        for (int i = 0; i < 600; i++) begin
            lk = ($urandom_range(0, 2) != 0);
            arm(20, 60, 60, 'h300, 32);
            run_cycle();
        end
        lk = 1'b0;
        drain();

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
